// File: rtl/i_cache_pkg.sv
// rtl/i_cache_pkg.sv - shared types and width helpers for the 2-way instruction cache
package i_cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    FLUSH  = 2'd2
  } state_e;

  function automatic int tag_width(input int a_width, input int c_index, input int l_words);
    return a_width - c_index - l_words - 2;
  endfunction

  function automatic int index_width(input int c_index);
    return c_index;
  endfunction

  // One-word lines still need a 1-bit beat counter to hold a legal vector.
  function automatic int offset_width(input int l_words);
    return (l_words > 0) ? l_words : 1;
  endfunction

endpackage

// File: rtl/i_cache_way.sv
// rtl/i_cache_way.sv - one way of the cache: valid/tag/data storage, lookup and write port
module i_cache_way #(
  parameter int C_INDEX = 6,
  parameter int L_WORDS = 2,
  parameter int T_WIDTH = 22
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [C_INDEX-1:0]         rd_set,
  input  logic [C_INDEX+L_WORDS-1:0] rd_word,
  input  logic [T_WIDTH-1:0]         rd_tag,
  output logic                       hit,
  output logic                       valid,
  output logic [31:0]                rd_data,
  input  logic                       wr_en,
  input  logic [C_INDEX+L_WORDS-1:0] wr_word,
  input  logic [31:0]                wr_data,
  input  logic                       inst_en,
  input  logic [C_INDEX-1:0]         inst_set,
  input  logic [T_WIDTH-1:0]         inst_tag,
  input  logic                       inval_en,
  input  logic [C_INDEX-1:0]         inval_set
);

  localparam int SETS        = 1 << C_INDEX;
  localparam int WORDS_TOTAL = 1 << (C_INDEX + L_WORDS);

  logic [SETS-1:0]    valid_q, valid_d;
  logic [T_WIDTH-1:0] tag_mem  [SETS];
  logic [31:0]        data_mem [WORDS_TOTAL];

  always_comb begin
    valid_d = valid_q;
    if (inval_en) valid_d[inval_set] = 1'b0;
    if (inst_en)  valid_d[inst_set]  = 1'b1;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tags and data carry no reset; the valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (inst_en) tag_mem[inst_set] <= inst_tag;
    if (wr_en)   data_mem[wr_word] <= wr_data;
  end

  assign valid   = valid_q[rd_set];
  assign hit     = valid & (tag_mem[rd_set] == rd_tag);
  assign rd_data = data_mem[rd_word];

endmodule

// File: rtl/i_cache_2way.sv
// rtl/i_cache_2way.sv - 2-way set-associative i-cache with LRU, burst refill and flush sweep
module i_cache_2way #(
  parameter int A_WIDTH = 32,
  parameter int C_INDEX = 6,
  parameter int L_WORDS = 2
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [A_WIDTH-1:0] p_a,
  input  logic               p_strobe,
  output logic [31:0]        p_din,
  output logic               p_ready,
  output logic               cache_miss,
  output logic [A_WIDTH-1:0] m_a,
  output logic               m_strobe,
  input  logic [31:0]        m_dout,
  input  logic               m_ready,
  input  logic               flush,
  output logic               flush_busy
);
  import i_cache_pkg::*;

  localparam int T_WIDTH = tag_width(A_WIDTH, C_INDEX, L_WORDS);
  localparam int I_WIDTH = index_width(C_INDEX);
  localparam int CNT_W   = offset_width(L_WORDS);
  localparam int W_AW    = C_INDEX + L_WORDS;
  localparam int SETS    = 1 << C_INDEX;
  localparam int WORDS   = 1 << L_WORDS;
  localparam logic [A_WIDTH-1:0] OFF_MASK  = A_WIDTH'(WORDS * 4 - 1);
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(WORDS - 1);
  localparam logic [I_WIDTH-1:0] LAST_SET  = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [I_WIDTH-1:0] fcnt_q, fcnt_d;
  logic [A_WIDTH-1:0] base_q, base_d;
  logic               victim_q, victim_d;
  logic               pend_q, pend_d;
  logic [SETS-1:0]    lru_q, lru_d;

  logic [I_WIDTH-1:0] p_index, r_index;
  logic [T_WIDTH-1:0] p_tag, r_tag;
  logic [W_AW-1:0]    p_word, r_word;
  logic               hit0, hit1, valid0, valid1, any_hit, victim_sel, last_beat;
  logic [31:0]        data0, data1;
  logic               refill_wr, install, inval_victim, flush_inval;
  logic [I_WIDTH-1:0] inval_set;
  logic [1:0]         unused_pa;

  assign p_index   = p_a[C_INDEX+L_WORDS+1:L_WORDS+2];
  assign p_tag     = p_a[A_WIDTH-1:A_WIDTH-T_WIDTH];
  assign p_word    = p_a[W_AW+1:2];
  assign unused_pa = p_a[1:0];

  // The beat offset is OR-ed into a zeroed offset field, so it can never carry into the index.
  assign m_a       = base_q | (A_WIDTH'(cnt_q) << 2);
  assign r_index   = base_q[C_INDEX+L_WORDS+1:L_WORDS+2];
  assign r_tag     = base_q[A_WIDTH-1:A_WIDTH-T_WIDTH];
  assign r_word    = m_a[W_AW+1:2];
  assign last_beat = (cnt_q == LAST_BEAT);

  assign any_hit    = hit0 | hit1;
  assign p_din      = hit0 ? data0 : data1;
  assign victim_sel = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : ~lru_q[p_index]);
  assign inval_set  = flush_inval ? fcnt_q : p_index;

  i_cache_way #(.C_INDEX(C_INDEX), .L_WORDS(L_WORDS), .T_WIDTH(T_WIDTH)) u_way0 (
    .clk(clk), .clr(clr),
    .rd_set(p_index), .rd_word(p_word), .rd_tag(p_tag),
    .hit(hit0), .valid(valid0), .rd_data(data0),
    .wr_en(refill_wr & ~victim_q), .wr_word(r_word), .wr_data(m_dout),
    .inst_en(install & ~victim_q), .inst_set(r_index), .inst_tag(r_tag),
    .inval_en(flush_inval | (inval_victim & ~victim_sel)), .inval_set(inval_set)
  );

  i_cache_way #(.C_INDEX(C_INDEX), .L_WORDS(L_WORDS), .T_WIDTH(T_WIDTH)) u_way1 (
    .clk(clk), .clr(clr),
    .rd_set(p_index), .rd_word(p_word), .rd_tag(p_tag),
    .hit(hit1), .valid(valid1), .rd_data(data1),
    .wr_en(refill_wr & victim_q), .wr_word(r_word), .wr_data(m_dout),
    .inst_en(install & victim_q), .inst_set(r_index), .inst_tag(r_tag),
    .inval_en(flush_inval | (inval_victim & victim_sel)), .inval_set(inval_set)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fcnt_q   <= '0;
      base_q   <= '0;
      victim_q <= 1'b0;
      pend_q   <= 1'b0;
      lru_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      base_q   <= base_d;
      victim_q <= victim_d;
      pend_q   <= pend_d;
      lru_q    <= lru_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    base_d   = base_q;
    victim_d = victim_q;
    lru_d    = lru_q;
    // A pending flush is consumed only when IDLE launches the sweep.
    pend_d   = flush | (pend_q & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = FLUSH;
        end else if (p_strobe) begin
          if (any_hit) begin
            lru_d[p_index] = ~hit0;
          end else begin
            state_d  = REFILL;
            base_d   = p_a & ~OFF_MASK;
            victim_d = victim_sel;
            cnt_d    = '0;
          end
        end
      end
      REFILL: begin
        if (m_ready) begin
          if (last_beat) begin
            cnt_d          = '0;
            lru_d[r_index] = victim_q;
            state_d        = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == LAST_SET) begin
          state_d = IDLE;
          lru_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p_ready      = 1'b0;
    cache_miss   = 1'b0;
    m_strobe     = 1'b0;
    refill_wr    = 1'b0;
    install      = 1'b0;
    inval_victim = 1'b0;
    flush_inval  = 1'b0;
    flush_busy   = pend_q | (state_q == FLUSH);
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          cache_miss = p_strobe;
        end else if (p_strobe) begin
          if (any_hit) begin
            p_ready = 1'b1;
          end else begin
            cache_miss   = 1'b1;
            inval_victim = 1'b1;
          end
        end
      end
      REFILL: begin
        m_strobe   = 1'b1;
        cache_miss = 1'b1;
        refill_wr  = m_ready;
        install    = m_ready & last_beat;
      end
      FLUSH: begin
        cache_miss  = p_strobe;
        flush_inval = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i_cache_2way.sv
// tb/tb_i_cache_2way.sv - directed self-checking bench for i_cache_2way
module tb_i_cache_2way;

  logic        clk;
  logic        clr;
  logic [31:0] p_a;
  logic        p_strobe;
  logic [31:0] p_din;
  logic        p_ready;
  logic        cache_miss;
  logic [31:0] m_a;
  logic        m_strobe;
  logic [31:0] m_dout;
  logic        m_ready;
  logic        flush;
  logic        flush_busy;

  int          errors;
  int          checks;
  logic [31:0] salt;
  logic [31:0] beat_log[$];
  logic [31:0] cyc_log[$];
  bit          rdy_pat[$];
  bit          miss_low;

  i_cache_2way #(.A_WIDTH(32), .C_INDEX(6), .L_WORDS(2)) dut (
    .clk(clk), .clr(clr), .p_a(p_a), .p_strobe(p_strobe), .p_din(p_din),
    .p_ready(p_ready), .cache_miss(cache_miss), .m_a(m_a), .m_strobe(m_strobe),
    .m_dout(m_dout), .m_ready(m_ready), .flush(flush), .flush_busy(flush_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_dout = m_a ^ 32'h5A00_0000 ^ salt;

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A00_0000 ^ salt;
  endfunction

  // Holds a fetch until p_ready; logs every strobe cycle and every accepted beat.
  task automatic do_fetch(input logic [31:0] a, input int flush_beat,
                          output logic [31:0] data, output int lat);
    int beats;
    beats = 0;
    lat = -1;
    data = 32'hx;
    miss_low = 1'b0;
    beat_log.delete();
    cyc_log.delete();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      p_a = a; p_strobe = 1'b1; flush = 1'b0; m_ready = 1'b0;
      #1;
      if (m_strobe) begin
        m_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
        flush = (beats == flush_beat);
        cyc_log.push_back(m_a);
        if (m_ready) begin
          beat_log.push_back(m_a);
          beats++;
        end
      end
      #1;
      if (p_ready) begin
        data = p_din;
        lat = c;
        break;
      end
      if (!cache_miss) miss_low = 1'b1;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; p_a = 32'h100; p_strobe = 1'b1; flush = 1'b0; m_ready = 1'b1;
    #1;
    checks++; if (m_strobe !== 1'b0) begin errors++; $display("FAIL reset_m_strobe got=%b exp=0", m_strobe); end
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL reset_flush_busy got=%b exp=0", flush_busy); end
    checks++; if (p_ready !== 1'b0) begin errors++; $display("FAIL reset_p_ready got=%b exp=0", p_ready); end
    checks++; if (cache_miss !== 1'b1) begin errors++; $display("FAIL reset_cache_miss got=%b exp=1", cache_miss); end
    repeat (3) @(negedge clk);
    p_strobe = 1'b0;
    #1;
    checks++; if (cache_miss !== 1'b0) begin errors++; $display("FAIL reset_miss_idle got=%b exp=0", cache_miss); end
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cold();
    logic [31:0] d;
    int lat;
    do_fetch(32'h100, -1, d, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL cold_latency got=%0d exp=5", lat); end
    checks++; if (beat_log.size() !== 4) begin errors++; $display("FAIL cold_beats got=%0d exp=4", beat_log.size()); end
    for (int i = 0; i < 4 && i < beat_log.size(); i++) begin
      checks++;
      if (beat_log[i] !== 32'h100 + 32'(4 * i)) begin
        errors++; $display("FAIL cold_m_a[%0d] got=%h exp=%h", i, beat_log[i], 32'h100 + 32'(4 * i));
      end
    end
    checks++; if (d !== exp_word(32'h100)) begin errors++; $display("FAIL cold_data got=%h exp=%h", d, exp_word(32'h100)); end
    checks++; if (miss_low !== 1'b0) begin errors++; $display("FAIL cold_cache_miss got=low exp=high"); end
    for (int i = 1; i < 4; i++) begin
      do_fetch(32'h100 + 32'(4 * i), -1, d, lat);
      checks++; if (lat !== 0) begin errors++; $display("FAIL cold_hit_lat[%0d] got=%0d exp=0", i, lat); end
      checks++; if (cyc_log.size() !== 0) begin errors++; $display("FAIL cold_hit_strobe[%0d] got=%0d exp=0", i, cyc_log.size()); end
      checks++;
      if (d !== exp_word(32'h100 + 32'(4 * i))) begin
        errors++; $display("FAIL cold_hit_data[%0d] got=%h exp=%h", i, d, exp_word(32'h100 + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_conflict();
    logic [31:0] d;
    int lat;
    do_fetch(32'h500, -1, d, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL conf_fill500 got=%0d exp=5", lat); end
    do_fetch(32'h100, -1, d, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL conf_hit100 got=%0d exp=0", lat); end
    do_fetch(32'h504, -1, d, lat);
    checks++; if (lat !== 0 || d !== exp_word(32'h504)) begin errors++; $display("FAIL conf_hit504 lat=%0d data=%h exp_lat=0 exp_data=%h", lat, d, exp_word(32'h504)); end
    do_fetch(32'h100, -1, d, lat);
    do_fetch(32'h908, -1, d, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL conf_miss900 got=%0d exp=5", lat); end
    checks++; if (d !== exp_word(32'h908)) begin errors++; $display("FAIL conf_data908 got=%h exp=%h", d, exp_word(32'h908)); end
    checks++; if (beat_log.size() > 0 && beat_log[0] !== 32'h900) begin errors++; $display("FAIL conf_base900 got=%h exp=00000900", beat_log[0]); end
    do_fetch(32'h10C, -1, d, lat);
    checks++; if (lat !== 0 || d !== exp_word(32'h10C)) begin errors++; $display("FAIL conf_keep100 lat=%0d data=%h exp_lat=0", lat, d); end
    do_fetch(32'h900, -1, d, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL conf_hit900 got=%0d exp=0", lat); end
    do_fetch(32'h500, -1, d, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL conf_evicted500 got=%0d exp=5", lat); end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    int lat;
    logic [31:0] exp_cyc[7];
    exp_cyc = '{32'h2040, 32'h2044, 32'h2044, 32'h2044, 32'h2048, 32'h2048, 32'h204C};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_fetch(32'h2040, -1, d, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL stall_latency got=%0d exp=8", lat); end
    checks++; if (cyc_log.size() !== 7) begin errors++; $display("FAIL stall_cycles got=%0d exp=7", cyc_log.size()); end
    for (int i = 0; i < 7 && i < cyc_log.size(); i++) begin
      checks++;
      if (cyc_log[i] !== exp_cyc[i]) begin errors++; $display("FAIL stall_m_a[%0d] got=%h exp=%h", i, cyc_log[i], exp_cyc[i]); end
    end
    checks++; if (miss_low !== 1'b0) begin errors++; $display("FAIL stall_cache_miss got=low exp=high"); end
    for (int i = 0; i < 4; i++) begin
      do_fetch(32'h2040 + 32'(4 * i), -1, d, lat);
      checks++;
      if (lat !== 0 || d !== exp_word(32'h2040 + 32'(4 * i))) begin
        errors++; $display("FAIL stall_word[%0d] lat=%0d data=%h exp=%h", i, lat, d, exp_word(32'h2040 + 32'(4 * i)));
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int lat;
    int busy;
    bit bad;
    busy = 0;
    bad = 1'b0;
    @(negedge clk);
    p_strobe = 1'b0; flush = 1'b1; m_ready = 1'b0;
    #1;
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL flush_busy_early got=%b exp=0", flush_busy); end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      flush = 1'b0;
      #1;
      if (!flush_busy) begin
        p_strobe = 1'b0;
        break;
      end
      busy++;
      p_a = 32'h100; p_strobe = 1'b1;
      #1;
      if (p_ready !== 1'b0 || cache_miss !== 1'b1 || m_strobe !== 1'b0) bad = 1'b1;
    end
    checks++; if (busy !== 65) begin errors++; $display("FAIL flush_busy_cycles got=%0d exp=65", busy); end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL flush_outputs got=bad exp=p_ready0_miss1_strobe0"); end
    salt = 32'h0013_5700;
    do_fetch(32'h100, -1, d, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL flush_refill_lat got=%0d exp=5", lat); end
    checks++; if (d !== exp_word(32'h100)) begin errors++; $display("FAIL flush_refill_data got=%h exp=%h", d, exp_word(32'h100)); end
    do_fetch(32'h2040, -1, d, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL flush_other_line got=%0d exp=5", lat); end
  endtask

  task automatic test_flush_during_refill();
    logic [31:0] d;
    int lat;
    do_fetch(32'h3000, 1, d, lat);
    checks++; if (lat !== 75) begin errors++; $display("FAIL fdr_latency got=%0d exp=75", lat); end
    checks++; if (beat_log.size() !== 8) begin errors++; $display("FAIL fdr_beats got=%0d exp=8", beat_log.size()); end
    for (int i = 0; i < 8 && i < beat_log.size(); i++) begin
      checks++;
      if (beat_log[i] !== 32'h3000 + 32'(4 * (i % 4))) begin
        errors++; $display("FAIL fdr_m_a[%0d] got=%h exp=%h", i, beat_log[i], 32'h3000 + 32'(4 * (i % 4)));
      end
    end
    checks++; if (d !== exp_word(32'h3000)) begin errors++; $display("FAIL fdr_data got=%h exp=%h", d, exp_word(32'h3000)); end
    checks++; if (miss_low !== 1'b0) begin errors++; $display("FAIL fdr_cache_miss got=low exp=high"); end
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL fdr_busy_end got=%b exp=0", flush_busy); end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] d;
    int lat;
    do_fetch(32'h100, -1, d, lat);
    do_fetch(32'h104, -1, d, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL rst_prefill got=%0d exp=0", lat); end
    @(negedge clk);
    p_a = 32'h4000; p_strobe = 1'b1; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (m_strobe !== 1'b1 || m_a !== 32'h4008) begin errors++; $display("FAIL rst_beat2 strobe=%b m_a=%h exp=1/00004008", m_strobe, m_a); end
    clr = 1'b1;
    #1;
    checks++; if (m_strobe !== 1'b0) begin errors++; $display("FAIL rst_mid_strobe got=%b exp=0", m_strobe); end
    checks++; if (cache_miss !== 1'b1 || p_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs miss=%b ready=%b exp=1/0", cache_miss, p_ready); end
    checks++; if (flush_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", flush_busy); end
    @(negedge clk);
    clr = 1'b0; p_strobe = 1'b0;
    do_fetch(32'h100, -1, d, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL rst_old_line got=%0d exp=5", lat); end
    do_fetch(32'h400C, -1, d, lat);
    checks++; if (lat !== 5 || d !== exp_word(32'h400C)) begin errors++; $display("FAIL rst_new_line lat=%0d data=%h exp=5/%h", lat, d, exp_word(32'h400C)); end
    checks++; if (beat_log.size() > 0 && beat_log[0] !== 32'h4000) begin errors++; $display("FAIL rst_restart got=%h exp=00004000", beat_log[0]); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    salt = 32'h0;
    test_reset();
    test_cold();
    test_conflict();
    test_stall();
    test_flush();
    test_flush_during_refill();
    test_reset_mid_refill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
